// File: rtl/apb_regfile_param_if.sv
// ---------------------------------------------------------------------------
// apb_regfile_param_if
// APB3/APB4 bus bundle between the bridge (master) and a register-file
// completer (slave). The clock and reset are not part of the bundle.
//
// Parameters:
//   ADDR_W  width of paddr
//   DATA_W  width of pwdata/prdata (multiple of 8)
//
// Signals:
//   paddr, pwdata, pstrb, psel, penable, pwrite   master -> slave
//   pready, pslverr, prdata                       slave  -> master
// ---------------------------------------------------------------------------
interface apb_regfile_param_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   paddr;
  logic [DATA_W-1:0]   pwdata;
  logic [DATA_W/8-1:0] pstrb;
  logic                psel;
  logic                penable;
  logic                pwrite;
  logic                pready;
  logic                pslverr;
  logic [DATA_W-1:0]   prdata;

  modport master (
    output paddr, pwdata, pstrb, psel, penable, pwrite,
    input  pready, pslverr, prdata
  );

  modport slave (
    input  paddr, pwdata, pstrb, psel, penable, pwrite,
    output pready, pslverr, prdata
  );
endinterface

// File: rtl/apb_regfile_param.sv
// ---------------------------------------------------------------------------
// apb_regfile_param
// Parametrised APB completer: NUM_REGS read/write registers followed by one
// read-only ID register. Registers live at word index 0..NUM_REGS-1, the ID
// register at index NUM_REGS; everything above is unmapped. Unaligned
// accesses, unmapped accesses and writes to ID complete with pslverr=1 and
// leave all state untouched.
//
// Optional feature (compile-time macro STRB_EN):
//   defined   - writes honour pstrb per byte; pstrb=0 is a legal no-op.
//   undefined - pstrb is ignored and every mapped write updates the word.
//
// Ports:
//   pclk       clock, rising edge
//   preset     asynchronous active-high reset
//   bus        APB slave modport (paddr/pwdata/pstrb/psel/penable/pwrite in,
//              pready/pslverr/prdata out, all outputs registered)
//   regs_flat  all RW registers, reg k at [k*DATA_W +: DATA_W]
// ---------------------------------------------------------------------------
module apb_regfile_param #(
  parameter int                DATA_W      = 32,
  parameter int                NUM_REGS    = 16,
  parameter int                ADDR_W      = 12,
  parameter int                WAIT_STATES = 0,
  parameter logic [DATA_W-1:0] RESET_VAL   = '0,
  parameter logic [31:0]       ID_VALUE    = 32'h5A50_0001
) (
  input  logic                       pclk,
  input  logic                       preset,
  apb_regfile_param_if.slave         bus,
  output logic [NUM_REGS*DATA_W-1:0] regs_flat
);

  localparam int IDX_W     = ADDR_W - 2;
  localparam int REG_IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int STRB_W    = DATA_W / 8;

  localparam logic [IDX_W-1:0]  NUM_REGS_IDX = IDX_W'(NUM_REGS);
  localparam logic [DATA_W-1:0] ID_WORD      = DATA_W'(ID_VALUE);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t              state_reg;
  logic [3:0]          cnt_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic [DATA_W-1:0]   wdata_reg;
  logic                write_reg;
  logic                pready_reg;
  logic                pslverr_reg;
  logic [DATA_W-1:0]   prdata_reg;
  logic [DATA_W-1:0]   regs [NUM_REGS];

`ifdef STRB_EN
  logic [STRB_W-1:0]   strb_reg;
`else
  logic                unused_strb;
  assign unused_strb = ^bus.pstrb;
`endif

  // Decode of the latched request; only consumed on the completing edge.
  logic [IDX_W-1:0]     idx;
  logic [REG_IDX_W-1:0] reg_sel;
  logic                 is_rw;
  logic                 is_id;
  logic                 dec_err;
  logic [DATA_W-1:0]    rd_val;
  logic [DATA_W-1:0]    wr_word;

  always_comb begin
    idx     = addr_reg[ADDR_W-1:2];
    reg_sel = idx[REG_IDX_W-1:0];
    is_rw   = (idx < NUM_REGS_IDX);
    is_id   = (idx == NUM_REGS_IDX);
    dec_err = (addr_reg[1:0] != 2'b00) || !(is_rw || is_id) || (is_id && write_reg);

    rd_val = '0;
    if (!dec_err && !write_reg) begin
      rd_val = is_id ? ID_WORD : regs[reg_sel];
    end

`ifdef STRB_EN
    wr_word = regs[reg_sel];
    for (int b = 0; b < STRB_W; b++) begin
      if (strb_reg[b]) begin
        wr_word[b*8 +: 8] = wdata_reg[b*8 +: 8];
      end
    end
`else
    wr_word = wdata_reg;
`endif
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      addr_reg    <= '0;
      wdata_reg   <= '0;
      write_reg   <= 1'b0;
      pready_reg  <= 1'b0;
      pslverr_reg <= 1'b0;
      prdata_reg  <= '0;
`ifdef STRB_EN
      strb_reg    <= '0;
`endif
      for (int k = 0; k < NUM_REGS; k++) begin
        regs[k] <= RESET_VAL;
      end
    end else begin
      case (state_reg)
        IDLE: begin
          pready_reg  <= 1'b0;
          pslverr_reg <= 1'b0;
          prdata_reg  <= '0;
          // penable=1 without a preceding setup phase is not a transfer.
          if (bus.psel && !bus.penable) begin
            addr_reg  <= bus.paddr;
            wdata_reg <= bus.pwdata;
            write_reg <= bus.pwrite;
`ifdef STRB_EN
            strb_reg  <= bus.pstrb;
`endif
            cnt_reg   <= 4'(WAIT_STATES);
            state_reg <= ACCESS;
          end
        end

        ACCESS: begin
          if (!bus.psel) begin
            // Master abandoned the transfer: nothing is committed.
            state_reg <= IDLE;
          end else if (bus.penable) begin
            if (cnt_reg != 4'd0) begin
              cnt_reg <= cnt_reg - 4'd1;
            end else begin
              pready_reg  <= 1'b1;
              pslverr_reg <= dec_err;
              prdata_reg  <= rd_val;
              if (!dec_err && write_reg) begin
                regs[reg_sel] <= wr_word;
              end
              state_reg <= RESP;
            end
          end
        end

        RESP: begin
          pready_reg  <= 1'b0;
          pslverr_reg <= 1'b0;
          prdata_reg  <= '0;
          state_reg   <= IDLE;
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.pready  = pready_reg;
  assign bus.pslverr = pslverr_reg;
  assign bus.prdata  = prdata_reg;

  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_flat
      assign regs_flat[gi*DATA_W +: DATA_W] = regs[gi];
    end
  endgenerate

endmodule
